// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the byte-wide instruction memory and the decoder.
// master = sequencer side, slave = memory/decoder side.
interface fetch_sequencer_if #(
  parameter int I_ADDR_W     = 12,
  parameter int INST_W_BYTES = 2,
  parameter int MEM_W        = 8
);
  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
  // A source holds valid and its payload stable until that edge. mem_rsp_valid carries no
  // ready: it is a one-cycle data strobe answering the single outstanding request.
  logic                          mem_req_valid;
  logic [I_ADDR_W-1:0]           mem_req_addr;
  logic                          mem_req_ready;
  logic                          mem_rsp_valid;
  logic [MEM_W-1:0]              mem_rsp_data;
  logic [INST_W_BYTES*MEM_W-1:0] instr;
  logic [I_ADDR_W-1:0]           instr_pc;
  logic                          instr_valid;
  logic                          instr_ready;

  modport master (
    output mem_req_valid, mem_req_addr, instr, instr_pc, instr_valid,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr, instr_pc, instr_valid,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch: reads INST_W_BYTES bytes at pc, assembles them little-endian,
// presents the instruction to the decoder and strobes pc_update_en once per accepted instruction.
module fetch_sequencer #(
  parameter int I_ADDR_W     = 12,
  parameter int INST_W_BYTES = 2,
  parameter int MEM_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [I_ADDR_W-1:0] pc,
  output logic                pc_update_en,
  input  logic                halt,
  output logic                halted,
  fetch_sequencer_if.master   bus,
  output logic [2:0]          state_dbg
);

  localparam int IDX_W = (INST_W_BYTES > 1) ? $clog2(INST_W_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INST_W_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_PRESENT  = 3'd3,
    S_ADVANCE  = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [INST_W_BYTES*MEM_W-1:0] instr_q;
  logic [I_ADDR_W-1:0]           instr_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // halt is only looked at on instruction boundaries, so a fetch in flight always completes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_REQ;
          idx_d   = '0;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (bus.mem_rsp_valid) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_PRESENT;
          end else begin
            state_d = S_REQ;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      S_PRESENT: begin
        if (bus.instr_ready) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_REQ;
          idx_d   = '0;
        end
      end
      S_HALT: begin
        if (!halt) begin
          state_d = S_REQ;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // pc is stable for the whole fetch, so sampling it during the byte-0 request is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_pc_q <= '0;
    end else if (state_q == S_REQ && idx_q == '0) begin
      instr_pc_q <= pc;
    end
  end

  // Responses are only accepted in WAIT_RSP; stray strobes elsewhere never touch instr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if (state_q == S_WAIT_RSP && bus.mem_rsp_valid) begin
      for (int b = 0; b < INST_W_BYTES; b++) begin
        if (idx_q == IDX_W'(b)) instr_q[b*MEM_W +: MEM_W] <= bus.mem_rsp_data;
      end
    end
  end

  always_comb begin
    bus.mem_req_valid = (state_q == S_REQ);
    bus.mem_req_addr  = (state_q == S_REQ) ? (pc + I_ADDR_W'(idx_q)) : '0;
    bus.instr_valid   = (state_q == S_PRESENT);
    bus.instr         = instr_q;
    bus.instr_pc      = instr_pc_q;
    pc_update_en      = (state_q == S_ADVANCE);
    halted            = (state_q == S_HALT);
    state_dbg         = state_q;
  end

endmodule
